// File: rtl/rbsp_bit_buffer_pkg.sv
// Shared constants for the RBSP bit buffer and its shift/insert datapath.
// Latency: n/a (constants only).
// Backpressure: n/a.
//
// Purpose : widths shared by rbsp_bit_buffer and rbsp_shift_insert.
// Contents: WORD_BITS (input word), BUF_BITS (bit buffer depth),
//           WIN_BITS (look-ahead window), MAX_FWD (largest legal advance),
//           CNT_BITS (fill-level counter width, holds 0..BUF_BITS).
package rbsp_bit_buffer_pkg;

  localparam int WORD_BITS = 32;
  localparam int BUF_BITS  = 64;
  localparam int WIN_BITS  = 16;
  localparam int MAX_FWD   = 16;
  localparam int CNT_BITS  = 7;

endpackage

// File: rtl/rbsp_shift_insert.sv
// Barrel-shifts the bit buffer by the consumed length and inserts a new word.
// Latency: purely combinational.
// Backpressure: none; the caller guarantees room before asserting accept.
//
// Ports:
//   bit_buf    in  64  current buffer, bit 63 is the next unconsumed bit
//   count      in  7   current fill level
//   consume    in  5   bits removed this cycle (already qualified)
//   in_data    in  32  word to append, bit 31 earliest
//   accept     in  1   append in_data this cycle
//   buf_next   out 64  next buffer contents
//   count_next out 7   next fill level
module rbsp_shift_insert
  import rbsp_bit_buffer_pkg::*;
(
  input  logic [BUF_BITS-1:0]  bit_buf,
  input  logic [CNT_BITS-1:0]  count,
  input  logic [4:0]           consume,
  input  logic [WORD_BITS-1:0] in_data,
  input  logic                 accept,
  output logic [BUF_BITS-1:0]  buf_next,
  output logic [CNT_BITS-1:0]  count_next
);

  logic [CNT_BITS-1:0] post_count;
  logic [BUF_BITS-1:0] word_aligned;

  // Insertion point is the fill level after the consume, so a word that
  // arrives in the same cycle as an advance lands directly after the last
  // surviving bit. Accept is only possible with count <= 32, hence
  // post_count <= 32 and the whole word fits.
  assign post_count   = count - {2'b00, consume};
  assign word_aligned = {in_data, {(BUF_BITS-WORD_BITS){1'b0}}} >> post_count;

  // Left shift brings zeros in at the bottom, keeping bits beyond count clear.
  assign buf_next   = (bit_buf << consume) | (accept ? word_aligned : '0);
  assign count_next = post_count + (accept ? CNT_BITS'(WORD_BITS) : '0);

endmodule

// File: rtl/rbsp_bit_buffer.sv
// 64-bit MSB-first RBSP bit buffer feeding a 16-bit look-ahead window.
// Latency: accepted word and forward_len both take effect after the same edge.
// Backpressure: in_ready drops when more than 32 bits are held, during flush
//               and while ena=0; it is a function of registered count only.
//
// Ports:
//   clk, rst_n   clock; synchronous active-low reset
//   ena          enable; 0 holds all state
//   flush        synchronous clear (priority over consume/accept)
//   in_data/in_valid/in_ready  32-bit word handshake, bit 31 earliest
//   forward_len  bits consumed this cycle (0..16)
//   rbsp         window, rbsp[0] is the next unconsumed bit
//   rbsp_valid   at least 16 bits held
//   bit_pos      bits consumed since reset/flush (wraps)
//   err          sticky protocol error
module rbsp_bit_buffer
  import rbsp_bit_buffer_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ena,
  input  logic        flush,
  input  logic [31:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  forward_len,
  output logic [0:15] rbsp,
  output logic        rbsp_valid,
  output logic [31:0] bit_pos,
  output logic        err
);

  logic [BUF_BITS-1:0] bit_buf;
  logic [CNT_BITS-1:0] count;
  logic [BUF_BITS-1:0] buf_next;
  logic [CNT_BITS-1:0] count_next;
  logic                fwd_too_long;
  logic                fwd_starved;
  logic                proto_err;
  logic [4:0]          consume;
  logic                accept;

  assign rbsp       = bit_buf[BUF_BITS-1 -: WIN_BITS];
  assign rbsp_valid = (count >= CNT_BITS'(WIN_BITS));
  assign in_ready   = ena & ~flush & (count <= CNT_BITS'(WORD_BITS));

  // An illegal advance is ignored entirely rather than partially applied,
  // so the window never moves past data that is not there.
  assign fwd_too_long = (forward_len > 5'(MAX_FWD));
  assign fwd_starved  = (forward_len != 5'd0) & ~rbsp_valid;
  assign proto_err    = fwd_too_long | fwd_starved;
  assign consume      = proto_err ? 5'd0 : forward_len;
  assign accept       = in_valid & in_ready;

  rbsp_shift_insert u_shift_insert (
    .bit_buf    (bit_buf),
    .count      (count),
    .consume    (consume),
    .in_data    (in_data),
    .accept     (accept),
    .buf_next   (buf_next),
    .count_next (count_next)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bit_buf <= '0;
      count   <= '0;
      bit_pos <= '0;
      err     <= 1'b0;
    end else if (ena) begin
      if (flush) begin
        bit_buf <= '0;
        count   <= '0;
        bit_pos <= '0;
        err     <= 1'b0;
      end else begin
        bit_buf <= buf_next;
        count   <= count_next;
        bit_pos <= bit_pos + 32'(consume);
        if (proto_err) err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rbsp_bit_buffer.sv
module tb_rbsp_bit_buffer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ena;
  logic        flush;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  forward_len;
  logic [0:15] rbsp;
  logic        rbsp_valid;
  logic [31:0] bit_pos;
  logic        err;

  always #5 clk = ~clk;

  rbsp_bit_buffer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ena         (ena),
    .flush       (flush),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .forward_len (forward_len),
    .rbsp        (rbsp),
    .rbsp_valid  (rbsp_valid),
    .bit_pos     (bit_pos),
    .err         (err)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One directed step: inputs, in_ready expected before the edge, and the
  // window/status expected after the edge.
  typedef struct {
    logic        ena;
    logic        flush;
    logic        vld;
    logic [31:0] dat;
    logic [4:0]  fwd;
    logic        rdy;
    logic [15:0] win;
    logic        win_vld;
    logic [31:0] pos;
    logic        err;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic e, input logic f, input logic v, input logic [31:0] d,
                     input logic [4:0] fw, input logic r, input logic [15:0] w,
                     input logic wv, input logic [31:0] p, input logic er);
    vec_t t;
    t.ena = e; t.flush = f; t.vld = v; t.dat = d; t.fwd = fw;
    t.rdy = r; t.win = w; t.win_vld = wv; t.pos = p; t.err = er;
    vecs.push_back(t);
  endtask

  // Bit-serial golden model: accepted bits queue up, consumed bits pop off.
  bit     bitq[$];
  int     model_pos;
  int     words;

  function automatic logic [15:0] model_win();
    logic [15:0] w = '0;
    for (int i = 0; i < 16; i++)
      if (i < bitq.size()) w[15-i] = bitq[i];
    return w;
  endfunction

  initial begin
    rst_n = 1'b0; ena = 1'b0; flush = 1'b0;
    in_data = '0; in_valid = 1'b0; forward_len = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_rbsp", 32'(rbsp), 32'h0);
    check("reset_rbsp_valid", 32'(rbsp_valid), 32'h0);
    check("reset_bit_pos", bit_pos, 32'h0);
    check("reset_err", 32'(err), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    //   ena flush vld data          fwd rdy  win       wv pos  err
    add(1, 0, 0, 32'h0,        0,  1, 16'h0000, 0, 0,  0); // idle
    add(1, 0, 1, 32'hA5C30F1E, 0,  1, 16'hA5C3, 1, 0,  0); // fill 1
    add(1, 0, 1, 32'h12345678, 0,  1, 16'hA5C3, 1, 0,  0); // fill 2 -> 64
    add(1, 0, 0, 32'h0,        0,  0, 16'hA5C3, 1, 0,  0); // full
    add(1, 0, 0, 32'h0,        5,  0, 16'hB861, 1, 5,  0); // advance 5
    add(1, 0, 0, 32'h0,        0,  0, 16'hB861, 1, 5,  0); // 59 still full
    add(1, 0, 0, 32'h0,        16, 0, 16'hE3C2, 1, 21, 0); // -> 43
    add(1, 0, 0, 32'h0,        11, 0, 16'h1234, 1, 32, 0); // -> 32
    add(1, 0, 1, 32'h9ABCDEF0, 16, 1, 16'h5678, 1, 48, 0); // consume+load -> 48
    add(1, 0, 0, 32'h0,        16, 0, 16'h9ABC, 1, 64, 0); // -> 32
    add(1, 0, 0, 32'h0,        16, 1, 16'hDEF0, 1, 80, 0); // -> 16
    add(1, 0, 0, 32'h0,        8,  1, 16'hF000, 0, 88, 0); // -> 8
    add(1, 0, 0, 32'h0,        3,  1, 16'hF000, 0, 88, 1); // underflow
    add(1, 0, 0, 32'h0,        0,  1, 16'hF000, 0, 88, 1); // sticky
    add(0, 0, 1, 32'h11111111, 7,  0, 16'hF000, 0, 88, 1); // ena gating x3
    add(0, 0, 1, 32'h11111111, 7,  0, 16'hF000, 0, 88, 1);
    add(0, 0, 1, 32'h11111111, 7,  0, 16'hF000, 0, 88, 1);
    add(1, 1, 1, 32'h22222222, 0,  0, 16'h0000, 0, 0,  0); // flush
    add(1, 0, 0, 32'h0,        0,  1, 16'h0000, 0, 0,  0);
    add(1, 0, 1, 32'hCAFEBABE, 0,  1, 16'hCAFE, 1, 0,  0);
    add(1, 0, 0, 32'h0,        17, 1, 16'hCAFE, 1, 0,  1); // too long
    add(1, 1, 0, 32'h0,        0,  0, 16'h0000, 0, 0,  0); // flush clears err

    foreach (vecs[i]) begin
      ena = vecs[i].ena; flush = vecs[i].flush; in_valid = vecs[i].vld;
      in_data = vecs[i].dat; forward_len = vecs[i].fwd;
      #1;
      check($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'(vecs[i].rdy));
      @(posedge clk); #1;
      check($sformatf("v%0d_rbsp", i), 32'(rbsp), 32'(vecs[i].win));
      check($sformatf("v%0d_rbsp_valid", i), 32'(rbsp_valid), 32'(vecs[i].win_vld));
      check($sformatf("v%0d_bit_pos", i), bit_pos, vecs[i].pos);
      check($sformatf("v%0d_err", i), 32'(err), 32'(vecs[i].err));
      @(negedge clk);
    end

    // Random stream against the bit-serial model.
    ena = 1'b1; flush = 1'b0;
    bitq.delete(); model_pos = 0; words = 0;
    for (int cyc = 0; cyc < 20000 && words < 1000; cyc++) begin
      logic exp_rdy;
      int   cons;
      in_valid    = ($urandom_range(0, 9) < 7);
      in_data     = $urandom;
      forward_len = (bitq.size() >= 16) ? 5'($urandom_range(0, 16)) : 5'd0;
      exp_rdy     = (bitq.size() <= 32);
      #1;
      check("rnd_in_ready", 32'(in_ready), 32'(exp_rdy));
      cons = (bitq.size() >= 16) ? int'(forward_len) : 0;
      for (int k = 0; k < cons; k++) void'(bitq.pop_front());
      model_pos += cons;
      if (in_valid && exp_rdy) begin
        for (int b = 31; b >= 0; b--) bitq.push_back(in_data[b]);
        words++;
      end
      @(posedge clk); #1;
      check("rnd_rbsp", 32'(rbsp), 32'(model_win()));
      check("rnd_rbsp_valid", 32'(rbsp_valid), 32'(bitq.size() >= 16));
      check("rnd_bit_pos", bit_pos, 32'(model_pos));
      check("rnd_err", 32'(err), 32'h0);
      @(negedge clk);
    end
    check("rnd_word_budget", 32'(words >= 1000), 32'h1);

    // Reset in the middle of a loaded stream.
    in_valid = 1'b0; forward_len = '0; rst_n = 1'b0;
    @(posedge clk); #1;
    check("midrst_rbsp", 32'(rbsp), 32'h0);
    check("midrst_rbsp_valid", 32'(rbsp_valid), 32'h0);
    check("midrst_bit_pos", bit_pos, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("midrst_in_ready", 32'(in_ready), 32'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
